fetch_unit: RTL
===============

# fetch_unit

Multi-cycle instruction fetch for the sequential Y86-64 core. It latches the PC produced by the PC-update stage and reads the instruction one byte per cycle from a byte-wide instruction memory. It then presents the decoded fields icode, ifun, rA, rB, valC and valP to decode/execute, along with validity and error flags. It is the consumer of the PC that the PC-update logic produces; its valP and valC feed back into that logic.

## Interface
- n, 64, address and constant width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to fetch the instruction at PC; sampled only in IDLE.
- PC  input  n  instruction address; latched on an accepted start.
- mem_addr  output  n  byte address to instruction memory.
- mem_data  input  8  byte at mem_addr; combinational, same cycle.
- mem_error  input  1  mem_addr is out of range; sampled together with mem_data.
- busy  output  1  high from an accepted start until done has been presented.
- done  output  1  one-cycle pulse; all decoded outputs are valid from this cycle.
- icode, ifun  output  4 each  fields of byte 0.
- rA, rB  output  4 each  fields of the register byte; 4'hF (RNONE) if the instruction has no register byte.
- valC  output  n  little-endian constant; 0 if the instruction has none.
- valP  output  n  address of the next sequential instruction.
- instr_valid  output  1  0 if icode > 4'hB.
- imem_error  output  1  memory error occurred during this fetch.

## Operation
- States: IDLE, BYTE0, REGS, CONST, DONE.
- Byte counter cnt:
  - mem_addr = PC_l + cnt, modulo 2^n.
  - mem_addr = 0 in IDLE.
- **IDLE**, start=1:
  - latch PC_l = PC, cnt = 0;
  - clear instr_valid, imem_error, valC;
  - set rA = rB = F;
  - go to BYTE0.
- **BYTE0**: capture icode = mem_data[7:4] and ifun = mem_data[3:0]. Instruction length L follows from icode:
  - L = 1: 0 halt, 1 nop, 9 ret; also invalid icode > B, which clears instr_valid.
  - L = 2: 2 rrmovq/cmov, 6 OPq, A pushq, B popq.
  - L = 10: 3 irmovq, 4 rmmovq, 5 mrmovq.
  - L = 9: 7 jXX, 8 call.
  - Next state: REGS if the instruction has a register byte, else CONST for 7/8, else DONE.
- **REGS**: capture rA = mem_data[7:4] and rB = mem_data[3:0]. Next state: CONST for 3/4/5, else DONE.
- **CONST**: 8 captures. Constant byte k is written to valC[8k+7:8k] (k = 0 first). Go to DONE after the 8th capture.
- **DONE**: assert done and set valP = PC_l + L (mod 2^n); return to IDLE next cycle.
- mem_error:
  - If mem_error = 1 at any capture edge, the byte is discarded and the fetch aborts to DONE.
  - On abort: imem_error = 1, icode = 1, ifun = 0 (bubble as nop), instr_valid = 1, valP = PC_l, valC = 0, rA = rB = F.
- Outputs hold their values from DONE until the next accepted start.

## Timing
- Reset (async): state IDLE, busy 0, done 0, mem_addr 0, icode 0, ifun 0, rA F, rB F, valC 0, valP 0, instr_valid 0, imem_error 0.
- Start accepted at rising edge e: byte i is captured at edge e+1+i, for i = 0..L-1.
- done is high in the cycle after edge e+L, for exactly one cycle. Start-to-done latency is L+1 cycles.
- busy is high for cycles e..e+L, including the done cycle. It falls with the return to IDLE.
- start while busy (including in DONE) is ignored and not queued. Back-to-back fetches need start re-asserted in IDLE.
- Abort at capture edge e+1+j: done follows in the next cycle. Latency is j+2.
- rst mid-fetch: immediate return to IDLE with reset values; no done pulse.

## Test plan
- **halt**:
  - Stimulus: memory[0] = 00, start with PC = 0.
  - Response: one capture; done 2 cycles after start with icode 0, rA/rB F, valP 1, instr_valid 1.
- **irmovq**:
  - Stimulus: memory[5..14] = 30 F3 0A 00 00 00 00 00 00 00, start with PC = 5.
  - Response: mem_addr steps 5..14; done after 11 cycles; icode 3, rA F, rB 3, valC 10, valP 15.
- **jXX**:
  - Stimulus: memory[20..28] = 73 20 00 00 00 00 00 00 00, PC = 20.
  - Response: icode 7, ifun 3, rA/rB F, valC 0x20, valP 29, done after 10 cycles.
- **invalid and wrap**:
  - Invalid byte C0 at PC = 40 gives instr_valid 0, valP 41.
  - OPq 60 12 at PC = 2^64−2 fetches from addresses …FE then …FF, giving rA 1, rB 2, valP 0.
- **mem_error**:
  - Stimulus: mrmovq at PC = 100 with mem_error raised on the 5th byte.
  - Response: done 6 cycles after start; imem_error 1, icode 1, valP 100, valC 0.
- **reset and ignored start**:
  - rst pulsed mid-CONST returns all outputs to reset values with no done pulse.
  - start pulsed while busy does not alter PC_l, and only one done is produced.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: PC-update request, byte-wide imem port
// and decoded instruction fields toward decode/execute.
interface fetch_unit_if;
  logic        start;
  logic [63:0] PC;
  logic [63:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_error;
  logic        busy;
  logic        done;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;

  modport master (
    output start, PC, mem_data, mem_error,
    input  mem_addr, busy, done, icode, ifun,
    input  rA, rB, valC, valP, instr_valid, imem_error
  );

  modport slave (
    input  start, PC, mem_data, mem_error,
    output mem_addr, busy, done, icode, ifun,
    output rA, rB, valC, valP, instr_valid, imem_error
  );
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle Y86-64 instruction fetch, one byte per cycle
// from a byte-wide instruction memory.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, BYTE0, REGS, CONST, DONE
  } state_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic [3:0]  cnt_q;
  logic [2:0]  k_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  icode_q;
  logic [3:0]  ifun_q;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [63:0] valc_q;
  logic [63:0] valp_q;
  logic        ivalid_q;
  logic        ierr_q;
  logic [63:0] addr_d;
  logic [3:0]  op_d;
  logic        capture;

  function automatic logic has_regs(input logic [3:0] ic);
    has_regs = (ic inside {4'h2, 4'h3, 4'h4, 4'h5,
                           4'h6, 4'hA, 4'hB});
  endfunction

  function automatic logic has_const(input logic [3:0] ic);
    has_const = (ic inside {4'h3, 4'h4, 4'h5,
                            4'h7, 4'h8});
  endfunction

  // Byte address walks PC_l + cnt; parked at 0 when idle.
  always_comb begin
    addr_d = '0;
    if (state_q != IDLE)
      addr_d = pc_q + {60'd0, cnt_q};
  end

  assign op_d    = bus.mem_data[7:4];
  assign capture = (state_q == BYTE0) ||
                   (state_q == REGS)  ||
                   (state_q == CONST);

  // Fetch FSM; a memory error on any capture overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      icode_q  <= 4'h0;
      ifun_q   <= 4'h0;
      ra_q     <= 4'hF;
      rb_q     <= 4'hF;
      valc_q   <= '0;
      valp_q   <= '0;
      ivalid_q <= 1'b0;
      ierr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            pc_q     <= bus.PC;
            cnt_q    <= '0;
            k_q      <= '0;
            ivalid_q <= 1'b0;
            ierr_q   <= 1'b0;
            valc_q   <= '0;
            ra_q     <= 4'hF;
            rb_q     <= 4'hF;
            busy_q   <= 1'b1;
            state_q  <= BYTE0;
          end
        end
        BYTE0: begin
          icode_q  <= op_d;
          ifun_q   <= bus.mem_data[3:0];
          ivalid_q <= (op_d <= 4'hB);
          cnt_q    <= cnt_q + 4'd1;
          if (has_regs(op_d)) begin
            state_q <= REGS;
          end else if (has_const(op_d)) begin
            state_q <= CONST;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            valp_q  <= addr_d + 64'd1;
          end
        end
        REGS: begin
          ra_q  <= bus.mem_data[7:4];
          rb_q  <= bus.mem_data[3:0];
          cnt_q <= cnt_q + 4'd1;
          if (has_const(icode_q)) begin
            state_q <= CONST;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            valp_q  <= addr_d + 64'd1;
          end
        end
        CONST: begin
          valc_q[{k_q, 3'b000} +: 8] <= bus.mem_data;
          k_q   <= k_q + 3'd1;
          cnt_q <= cnt_q + 4'd1;
          if (k_q == 3'd7) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            valp_q  <= addr_d + 64'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (capture && bus.mem_error) begin
        state_q  <= DONE;
        done_q   <= 1'b1;
        ierr_q   <= 1'b1;
        icode_q  <= 4'h1;
        ifun_q   <= 4'h0;
        ivalid_q <= 1'b1;
        valp_q   <= pc_q;
        valc_q   <= '0;
        ra_q     <= 4'hF;
        rb_q     <= 4'hF;
      end
    end
  end

  assign bus.mem_addr    = addr_d;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.icode       = icode_q;
  assign bus.ifun        = ifun_q;
  assign bus.rA          = ra_q;
  assign bus.rB          = rb_q;
  assign bus.valC        = valc_q;
  assign bus.valP        = valp_q;
  assign bus.instr_valid = ivalid_q;
  assign bus.imem_error  = ierr_q;

endmodule
